mem_port_arbiter: RTL and testbench

Shares one single-port synchronous memory between the core's instruction-fetch port and data port. Sits between the pipeline's fetch/data request outputs and the memory macro. Grants at most one access per cycle, inserts a write-recovery bubble, and routes read data back to the owner after a fixed latency. Returns per-port stall signals so the pipeline freezes the losing stage.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_rd_owner_pipe.sv | 37 +++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_WREC  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam int unsigned STARVE_MAX_DEF = 32'd3;
  localparam int unsigned MEM_LAT_DEF    = 32'd1;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_owner_pipe.sv
// MEM_LAT-deep shift register of {valid, owner} tags that steers returning
// read data to the port which issued the read.
module mem_port_arbiter_rd_owner_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_valid,
  input  owner_e push_owner,
  output logic   pop_i,
  output logic   pop_d
);

  rd_tag_t stage_r [MEM_LAT];

  // Shift tags one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_LAT); i++) begin
        stage_r[i].valid <= 1'b0;
        stage_r[i].owner <= OWN_I;
      end
    end else begin
      stage_r[0].valid <= push_valid;
      stage_r[0].owner <= push_owner;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign pop_i = stage_r[MEM_LAT-1].valid & (stage_r[MEM_LAT-1].owner == OWN_I);
  assign pop_d = stage_r[MEM_LAT-1].valid & (stage_r[MEM_LAT-1].owner == OWN_D);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data ports.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (fetch starvation guard).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 32'd30,
  parameter int unsigned DW         = 32'd32,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_stall,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_stall,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_rw,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam logic [2:0] STARVE_LIM = STARVE_MAX[2:0];

  arb_state_e state_r;
  logic       i_gnt_s;
  logic       d_gnt_s;
  logic       starving_s;
  logic [2:0] starve_cnt_s;
  logic       push_valid_s;
  owner_e     push_owner_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic GUARD_EN = 1'b1;
  logic [2:0] starve_cnt_r;

  // Count consecutive cycles the fetch port asks and is refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 3'd0;
    end else if (i_req && !i_gnt_s) begin
      starve_cnt_r <= sat_inc3(starve_cnt_r);
    end else begin
      starve_cnt_r <= 3'd0;
    end
  end

  assign starve_cnt_s = starve_cnt_r;
`else
  localparam logic GUARD_EN = 1'b0;
  assign starve_cnt_s = 3'd0;
`endif

  // Fetch only overrides data when it is actually asking this cycle.
  assign starving_s = GUARD_EN & (starve_cnt_s >= STARVE_LIM) & i_req;

  // Pick this cycle's winner; the write-recovery bubble blocks everyone.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (rst_n) begin
      case (state_r)
        ST_IDLE, ST_FETCH, ST_DATA: begin
          if (d_req && !starving_s) begin
            d_gnt_s = 1'b1;
          end else if (i_req) begin
            i_gnt_s = 1'b1;
          end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
          end
        end
        ST_WREC: begin
          i_gnt_s = 1'b0;
          d_gnt_s = 1'b0;
        end
        default: begin
          i_gnt_s = 1'b0;
          d_gnt_s = 1'b0;
        end
      endcase
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // State records who owned the memory in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (d_gnt_s) begin
      state_r <= d_rw ? ST_WREC : ST_DATA;
    end else if (i_gnt_s) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= ST_IDLE;
    end
  end

  // Route the winner onto the memory pins; idle pins stay at zero.
  always_comb begin
    m_req   = 1'b0;
    m_rw    = 1'b0;
    m_addr  = {AW{1'b0}};
    m_wdata = {DW{1'b0}};
    if (d_gnt_s) begin
      m_req   = 1'b1;
      m_rw    = d_rw;
      m_addr  = d_addr;
      m_wdata = d_rw ? d_wdata : {DW{1'b0}};
    end else if (i_gnt_s) begin
      m_req   = 1'b1;
      m_addr  = i_addr;
    end else begin
      m_req   = 1'b0;
    end
  end

  assign i_gnt   = i_gnt_s;
  assign d_gnt   = d_gnt_s;
  assign i_stall = rst_n & i_req & ~i_gnt_s;
  assign d_stall = rst_n & d_req & ~d_gnt_s;

  assign push_valid_s = i_gnt_s | (d_gnt_s & ~d_rw);
  assign push_owner_s = d_gnt_s ? OWN_D : OWN_I;

  mem_port_arbiter_rd_owner_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rd_owner_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid_s),
    .push_owner (push_owner_s),
    .pop_i      (i_rvalid),
    .pop_d      (d_rvalid)
  );

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: MEM_LAT=1 and MEM_LAT=3 instances share stimulus and
// are compared every cycle with a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          i_req, d_req, d_rw;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata_1, m_rdata_3;

  logic          i_gnt_1, i_stall_1, i_rvalid_1, d_gnt_1, d_stall_1, d_rvalid_1, m_req_1, m_rw_1;
  logic [DW-1:0] i_rdata_1, d_rdata_1, m_wdata_1;
  logic [AW-1:0] m_addr_1;
  logic          i_gnt_3, i_stall_3, i_rvalid_3, d_gnt_3, d_stall_3, d_rvalid_3, m_req_3, m_rw_3;
  logic [DW-1:0] i_rdata_3, d_rdata_3, m_wdata_3;
  logic [AW-1:0] m_addr_3;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_1), .i_stall(i_stall_1),
    .i_rvalid(i_rvalid_1), .i_rdata(i_rdata_1),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_1), .d_stall(d_stall_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
    .m_req(m_req_1), .m_rw(m_rw_1), .m_addr(m_addr_1), .m_wdata(m_wdata_1),
    .m_rdata(m_rdata_1)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_3), .i_stall(i_stall_3),
    .i_rvalid(i_rvalid_3), .i_rdata(i_rdata_3),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_3), .d_stall(d_stall_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
    .m_req(m_req_3), .m_rw(m_rw_3), .m_addr(m_addr_3), .m_wdata(m_wdata_3),
    .m_rdata(m_rdata_3)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: last access was a write, fetch denial streak, and
  // outstanding reads as (due cycle, owner) pairs per latency.
  typedef struct { int due; bit own; } rd_t;
  rd_t q1[$];
  rd_t q3[$];
  bit  mdl_prev_wr;
  int  mdl_starve;
  bit  e_ig, e_dg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic mdl_reset();
    q1.delete();
    q3.delete();
    mdl_prev_wr = 1'b0;
    mdl_starve  = 0;
  endtask

  task automatic mdl_eval();
    bit starving;
    if (!rst_n) begin
      e_ig = 1'b0;
      e_dg = 1'b0;
    end else begin
      starving = GUARD && (mdl_starve >= 3) && i_req;
      e_dg = !mdl_prev_wr && d_req && !starving;
      e_ig = !mdl_prev_wr && i_req && !e_dg;
    end
  endtask

  function automatic bit hit(input bit sel3, input bit own);
    if (sel3) begin
      foreach (q3[i]) if (q3[i].due == cyc && q3[i].own == own) return 1'b1;
    end else begin
      foreach (q1[i]) if (q1[i].due == cyc && q1[i].own == own) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_check();
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    bit es_i, es_d;
    mdl_eval();
    ea   = e_dg ? d_addr : (e_ig ? i_addr : '0);
    ew   = (e_dg && d_rw) ? d_wdata : '0;
    es_i = rst_n && i_req && !e_ig;
    es_d = rst_n && d_req && !e_dg;
    chk("l1.i_gnt",    64'(i_gnt_1),    64'(e_ig));
    chk("l1.d_gnt",    64'(d_gnt_1),    64'(e_dg));
    chk("l1.i_stall",  64'(i_stall_1),  64'(es_i));
    chk("l1.d_stall",  64'(d_stall_1),  64'(es_d));
    chk("l1.m_req",    64'(m_req_1),    64'(e_ig || e_dg));
    chk("l1.m_rw",     64'(m_rw_1),     64'(e_dg && d_rw));
    chk("l1.m_addr",   64'(m_addr_1),   64'(ea));
    chk("l1.m_wdata",  64'(m_wdata_1),  64'(ew));
    chk("l1.i_rvalid", 64'(i_rvalid_1), 64'(hit(1'b0, 1'b0)));
    chk("l1.d_rvalid", 64'(d_rvalid_1), 64'(hit(1'b0, 1'b1)));
    chk("l1.i_rdata",  64'(i_rdata_1),  64'(m_rdata_1));
    chk("l1.d_rdata",  64'(d_rdata_1),  64'(m_rdata_1));
    chk("l3.i_gnt",    64'(i_gnt_3),    64'(e_ig));
    chk("l3.d_gnt",    64'(d_gnt_3),    64'(e_dg));
    chk("l3.i_stall",  64'(i_stall_3),  64'(es_i));
    chk("l3.d_stall",  64'(d_stall_3),  64'(es_d));
    chk("l3.m_req",    64'(m_req_3),    64'(e_ig || e_dg));
    chk("l3.m_rw",     64'(m_rw_3),     64'(e_dg && d_rw));
    chk("l3.m_addr",   64'(m_addr_3),   64'(ea));
    chk("l3.m_wdata",  64'(m_wdata_3),  64'(ew));
    chk("l3.i_rvalid", 64'(i_rvalid_3), 64'(hit(1'b1, 1'b0)));
    chk("l3.d_rvalid", 64'(d_rvalid_3), 64'(hit(1'b1, 1'b1)));
    chk("l3.i_rdata",  64'(i_rdata_3),  64'(m_rdata_3));
    chk("l3.d_rdata",  64'(d_rdata_3),  64'(m_rdata_3));
  endtask

  task automatic model_update();
    if (!rst_n) begin
      mdl_reset();
    end else begin
      mdl_eval();
      if (e_ig) begin
        q1.push_back('{due: cyc + 1, own: 1'b0});
        q3.push_back('{due: cyc + 3, own: 1'b0});
      end
      if (e_dg && !d_rw) begin
        q1.push_back('{due: cyc + 1, own: 1'b1});
        q3.push_back('{due: cyc + 3, own: 1'b1});
      end
      mdl_prev_wr = e_dg && d_rw;
      if (i_req && !e_ig) mdl_starve = (mdl_starve < 7) ? mdl_starve + 1 : 7;
      else                mdl_starve = 0;
    end
    cyc++;
    while (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
    while (q3.size() > 0 && q3[0].due < cyc) void'(q3.pop_front());
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit drw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dw);
    i_req = ir; i_addr = ia; d_req = dr; d_rw = drw; d_addr = da; d_wdata = dw;
  endtask

  typedef struct {
    bit ir; logic [AW-1:0] ia; bit dr; bit drw; logic [AW-1:0] da; logic [DW-1:0] dw;
    logic [DW-1:0] mrd;
    bit eig; bit edg; bit eis; bit eds; bit emreq; bit emrw;
    logic [AW-1:0] emaddr; logic [DW-1:0] emwd; bit eirv; bit edrv;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Hand-derived vectors for the MEM_LAT=1 instance.
    tbl[0] = '{1'b1, 30'h10, 1'b0, 1'b0, 30'h0,  32'h0,  32'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h10, 32'h0,  1'b0, 1'b0};
    tbl[1] = '{1'b0, 30'h0,  1'b0, 1'b0, 30'h0,  32'h0,  32'hDEADBEEF,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0,  32'h0,  1'b1, 1'b0};
    tbl[2] = '{1'b1, 30'h40, 1'b1, 1'b0, 30'h20, 32'h0,  32'h0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 30'h20, 32'h0,  1'b0, 1'b0};
    tbl[3] = '{1'b1, 30'h40, 1'b0, 1'b0, 30'h0,  32'h0,  32'h11111111,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h40, 32'h0,  1'b0, 1'b1};
    tbl[4] = '{1'b0, 30'h0,  1'b0, 1'b0, 30'h0,  32'h0,  32'h22222222,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0,  32'h0,  1'b1, 1'b0};
    tbl[5] = '{1'b0, 30'h0,  1'b1, 1'b1, 30'h30, 32'h55, 32'h0,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 30'h30, 32'h55, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 30'h0,  1'b1, 1'b0, 30'h30, 32'h0,  32'h0,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 30'h0,  32'h0,  1'b0, 1'b0};
    tbl[7] = '{1'b0, 30'h0,  1'b1, 1'b0, 30'h30, 32'h0,  32'h0,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 30'h30, 32'h0,  1'b0, 1'b0};
    tbl[8] = '{1'b0, 30'h0,  1'b0, 1'b0, 30'h0,  32'h0,  32'h55,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0,  32'h0,  1'b0, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    m_rdata_1 = '0;
    m_rdata_3 = '0;
    mdl_reset();
    @(negedge clk);
    settle();
    tick();
    settle();
    tick();
    rst_n = 1'b1;

    // Table-driven basic transactions.
    for (int v = 0; v < 9; v++) begin
      drive(tbl[v].ir, tbl[v].ia, tbl[v].dr, tbl[v].drw, tbl[v].da, tbl[v].dw);
      m_rdata_1 = tbl[v].mrd;
      m_rdata_3 = $urandom;
      settle();
      chk($sformatf("tbl%0d.i_gnt", v),    64'(i_gnt_1),    64'(tbl[v].eig));
      chk($sformatf("tbl%0d.d_gnt", v),    64'(d_gnt_1),    64'(tbl[v].edg));
      chk($sformatf("tbl%0d.i_stall", v),  64'(i_stall_1),  64'(tbl[v].eis));
      chk($sformatf("tbl%0d.d_stall", v),  64'(d_stall_1),  64'(tbl[v].eds));
      chk($sformatf("tbl%0d.m_req", v),    64'(m_req_1),    64'(tbl[v].emreq));
      chk($sformatf("tbl%0d.m_rw", v),     64'(m_rw_1),     64'(tbl[v].emrw));
      chk($sformatf("tbl%0d.m_addr", v),   64'(m_addr_1),   64'(tbl[v].emaddr));
      chk($sformatf("tbl%0d.m_wdata", v),  64'(m_wdata_1),  64'(tbl[v].emwd));
      chk($sformatf("tbl%0d.i_rvalid", v), 64'(i_rvalid_1), 64'(tbl[v].eirv));
      chk($sformatf("tbl%0d.d_rvalid", v), 64'(d_rvalid_1), 64'(tbl[v].edrv));
      if (tbl[v].eirv) chk($sformatf("tbl%0d.i_rdata", v), 64'(i_rdata_1), 64'(tbl[v].mrd));
      if (tbl[v].edrv) chk($sformatf("tbl%0d.d_rdata", v), 64'(d_rdata_1), 64'(tbl[v].mrd));
      tick();
    end

    // Data reads held high against a persistent fetch request.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 30'h50, 1'b1, 1'b0, 30'h60, '0);
      settle();
      chk($sformatf("starve%0d.i_gnt", k), 64'(i_gnt_1), 64'(GUARD && (k % 4 == 3)));
      chk($sformatf("starve%0d.d_gnt", k), 64'(d_gnt_1), 64'(!(GUARD && (k % 4 == 3))));
      tick();
    end

    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      settle();
      tick();
    end

    // Back-to-back reads D, I, D observed through the MEM_LAT=3 instance.
    for (int k = 0; k < 7; k++) begin
      case (k)
        0:       drive(1'b0, '0,     1'b1, 1'b0, 30'h101, '0);
        1:       drive(1'b1, 30'h102, 1'b0, 1'b0, '0,      '0);
        2:       drive(1'b0, '0,     1'b1, 1'b0, 30'h103, '0);
        default: drive(1'b0, '0,     1'b0, 1'b0, '0,      '0);
      endcase
      m_rdata_3 = 32'hA000_0000 + 32'(k);
      settle();
      chk($sformatf("lat3_%0d.d_rvalid", k), 64'(d_rvalid_3), 64'(k == 3 || k == 5));
      chk($sformatf("lat3_%0d.i_rvalid", k), 64'(i_rvalid_3), 64'(k == 4));
      chk($sformatf("lat1_%0d.d_rvalid", k), 64'(d_rvalid_1), 64'(k == 1 || k == 3));
      chk($sformatf("lat1_%0d.i_rvalid", k), 64'(i_rvalid_1), 64'(k == 2));
      tick();
    end

    // Reset one cycle after a granted read kills the response.
    drive(1'b1, 30'h7, 1'b0, 1'b0, '0, '0);
    settle();
    chk("rst.pre_gnt", 64'(i_gnt_1), 64'd1);
    tick();
    rst_n = 1'b0;
    m_rdata_1 = '0;
    m_rdata_3 = '0;
    mdl_reset();
    settle();
    chk("rst.i_gnt",    64'(i_gnt_1),    64'd0);
    chk("rst.i_stall",  64'(i_stall_1),  64'd0);
    chk("rst.m_req",    64'(m_req_1),    64'd0);
    chk("rst.m_addr",   64'(m_addr_1),   64'd0);
    chk("rst.i_rvalid", 64'(i_rvalid_1), 64'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("rst.post%0d.i_rvalid3", k), 64'(i_rvalid_3), 64'd0);
      chk($sformatf("rst.post%0d.i_rvalid1", k), 64'(i_rvalid_1), 64'd0);
      tick();
    end
    drive(1'b1, 30'h9, 1'b0, 1'b0, '0, '0);
    settle();
    chk("rst.first.i_gnt",  64'(i_gnt_1),  64'd1);
    chk("rst.first.m_addr", 64'(m_addr_1), 64'h9);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    settle();
    chk("rst.first.i_rvalid", 64'(i_rvalid_1), 64'd1);
    tick();

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 30'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0), 30'($urandom), 32'($urandom));
      m_rdata_1 = $urandom;
      m_rdata_3 = $urandom;
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
